// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and flag layout.
// Flags are packed {N,Z,C,V}; the bit positions are fixed here so every user agrees.
package alu_pkg;

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_LSL = 4'b1011;
    localparam logic [3:0] OP_LSR = 4'b1100;
    localparam logic [3:0] OP_ASR = 4'b1101;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MUL_RUN = 2'b01,
        ST_HOLD    = 2'b10
    } alu_state_e;

    function automatic logic [3:0] make_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per clock, WIDTH iterations.
// done pulses combinationally during the final iteration; product then shows the finished value.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] partial_s;
    logic [WIDTH-1:0] acc_nx_s;
    logic             last_s;

    // Partial product for the current multiplier bit and the end-of-run detect.
    always_comb begin
        partial_s = {WIDTH{1'b0}};
        if (mplier_r[0]) begin
            partial_s = mcand_r;
        end else begin
            partial_s = {WIDTH{1'b0}};
        end
        acc_nx_s = acc_r + partial_s;
        last_s   = busy_r && (cnt_r == CNT_W'(WIDTH - 1));
    end

    assign done    = last_s;
    assign product = acc_nx_s;

    // Operand load on start, then one shift-add step per cycle while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r   <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
        end else if (start) begin
            busy_r   <= 1'b1;
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= op_a;
            mplier_r <= op_b;
        end else if (busy_r) begin
            acc_r    <= acc_nx_s;
            mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r + CNT_W'(1);
            busy_r   <= !last_s;
        end else begin
            busy_r   <= busy_r;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes, a registered status register and an
// iterative multiplier; single-cycle ops complete on acceptance, MUL takes WIDTH cycles more.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       alu_op,
    input  logic             c_in,
    input  logic             s_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [3:0]       status
);

    alu_state_e       state_r;
    alu_state_e       state_nx_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic [3:0]       flags_r;
    logic [3:0]       status_r;
    logic             sbit_r;
    logic [1:0]       mul_cv_r;

    logic             accept_s;
    logic             handoff_s;
    logic             is_mul_s;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_product_s;
    logic [3:0]       mul_flags_s;

    logic [SHAMT_W-1:0] amt_s;
    logic               add_cin_s;
    logic               sub_bin_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH:0]     shl_s;
    logic [WIDTH:0]     shr_s;
    logic signed [WIDTH:0] sar_in_s;
    logic [WIDTH:0]     sar_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic               alu_c_s;
    logic               alu_v_s;
    logic [3:0]         alu_flags_s;

    assign accept_s  = in_valid && in_ready_r && (state_r == ST_IDLE);
    assign handoff_s = out_valid_r && out_ready && (state_r == ST_HOLD);
    assign is_mul_s  = (alu_op == OP_MUL);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept_s && is_mul_s),
        .op_a    (src_a),
        .op_b    (src_b),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Carry/borrow selection and the wide arithmetic/shift intermediates.
    always_comb begin
        amt_s     = src_b[SHAMT_W-1:0];
        add_cin_s = 1'b0;
        sub_bin_s = 1'b0;
        if (alu_op == OP_ADC) begin
            add_cin_s = c_in;
        end else begin
            add_cin_s = 1'b0;
        end
        if (alu_op == OP_SBC) begin
            sub_bin_s = !c_in;
        end else begin
            sub_bin_s = 1'b0;
        end
        sum_s    = {1'b0, src_a} + {1'b0, src_b} + {{WIDTH{1'b0}}, add_cin_s};
        diff_s   = {1'b0, src_a} - {1'b0, src_b} - {{WIDTH{1'b0}}, sub_bin_s};
        // An extra bit below/above the operand catches the last bit shifted out.
        shl_s    = {1'b0, src_a} << amt_s;
        shr_s    = {src_a, 1'b0} >> amt_s;
        sar_in_s = {src_a, 1'b0};
        sar_s    = sar_in_s >>> amt_s;
    end

    // Single-cycle result and flag selection by opcode.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (alu_op)
            OP_MOV: alu_res_s = src_b;
            OP_MVN: alu_res_s = ~src_b;
            OP_ADD, OP_ADC: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_c_s   = sum_s[WIDTH];
                alu_v_s   = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                            (sum_s[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                alu_res_s = diff_s[WIDTH-1:0];
                alu_c_s   = !diff_s[WIDTH];
                alu_v_s   = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                            (diff_s[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND: alu_res_s = src_a & src_b;
            OP_ORR: alu_res_s = src_a | src_b;
            OP_EOR: alu_res_s = src_a ^ src_b;
            OP_LSL: begin
                alu_res_s = shl_s[WIDTH-1:0];
                alu_c_s   = shl_s[WIDTH];
            end
            OP_LSR: begin
                alu_res_s = shr_s[WIDTH:1];
                alu_c_s   = shr_s[0];
            end
            OP_ASR: begin
                alu_res_s = sar_s[WIDTH:1];
                alu_c_s   = sar_s[0];
            end
            OP_MUL: alu_res_s = {WIDTH{1'b0}};
            default: begin
                alu_res_s = {WIDTH{1'b0}};
                alu_c_s   = 1'b0;
                alu_v_s   = 1'b0;
            end
        endcase
        alu_flags_s = make_flags(alu_res_s[WIDTH-1], (alu_res_s == {WIDTH{1'b0}}),
                                 alu_c_s, alu_v_s);
        mul_flags_s = make_flags(mul_product_s[WIDTH-1],
                                 (mul_product_s == {WIDTH{1'b0}}),
                                 mul_cv_r[1], mul_cv_r[0]);
    end

    // FSM next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_mul_s) begin
                        state_nx_s = ST_MUL_RUN;
                    end else begin
                        state_nx_s = ST_HOLD;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MUL_RUN: begin
                if (mul_done_s) begin
                    state_nx_s = ST_HOLD;
                end else begin
                    state_nx_s = ST_MUL_RUN;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register; handshake outputs are registered copies of the next state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == ST_IDLE);
            out_valid_r <= (state_nx_s == ST_HOLD);
        end
    end

    // Operation capture and result/flag registers, held stable throughout HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= {WIDTH{1'b0}};
            flags_r  <= 4'b0000;
            sbit_r   <= 1'b0;
            mul_cv_r <= 2'b00;
        end else if (accept_s) begin
            sbit_r   <= s_bit;
            mul_cv_r <= {status_r[FLAG_C], status_r[FLAG_V]};
            if (!is_mul_s) begin
                result_r <= alu_res_s;
                flags_r  <= alu_flags_s;
            end else begin
                result_r <= result_r;
                flags_r  <= flags_r;
            end
        end else if ((state_r == ST_MUL_RUN) && mul_done_s) begin
            result_r <= mul_product_s;
            flags_r  <= mul_flags_s;
        end else begin
            result_r <= result_r;
            flags_r  <= flags_r;
        end
    end

    // Status register commits only when a flag-setting result is handed off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_r <= 4'b0000;
        end else if (handoff_s && sbit_r) begin
            status_r <= flags_r;
        end else begin
            status_r <= status_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign flags     = flags_r;
    assign status    = status_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: expected results are queued at acceptance and
// compared when the DUT presents them.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic [3:0]   alu_op = 4'b0000;
    logic         c_in = 1'b0;
    logic         s_bit = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic [3:0]   status;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src_a     (src_a),
        .src_b     (src_b),
        .alu_op    (alu_op),
        .c_in      (c_in),
        .s_bit     (s_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .status    (status)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic         sbit;
        int           lat;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         acc_cyc = 0;
    logic [3:0] exp_status = 4'b0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sb_in,
                        input logic [W-1:0] eres, input logic [3:0] eflg, input int elat);
        exp_t e;
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        alu_op = op; src_a = a; src_b = b; c_in = cin; s_bit = sb_in;
        e.res = eres; e.flg = eflg; e.sbit = sb_in; e.lat = elat;
        sb.push_back(e);
        tick();
        acc_cyc = cyc;
        // Scramble the inputs: the accepted operation must not notice.
        in_valid = 1'b0;
        src_a = $urandom; src_b = $urandom; alu_op = 4'($urandom_range(0, 15));
        c_in = 1'($urandom_range(0, 1)); s_bit = 1'($urandom_range(0, 1));
    endtask

    task automatic recv(input string name, input logic pre_ready, input int hold,
                        input logic busy_chk);
        exp_t e;
        int n = 0;
        int lat;
        logic busy_bad = 1'b0;
        out_ready = pre_ready;
        while (out_valid !== 1'b1 && n < 200) begin
            if (busy_chk && in_ready !== 1'b0) busy_bad = 1'b1;
            tick();
            n++;
        end
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%b required 1", name, out_valid);
            out_ready = 1'b0;
            return;
        end
        lat = cyc - acc_cyc + 1;
        checks++;
        if (result !== e.res) begin
            errors++;
            $display("FAIL %s_result: got %h required %h", name, result, e.res);
        end
        checks++;
        if (flags !== e.flg) begin
            errors++;
            $display("FAIL %s_flags: got %b required %b", name, flags, e.flg);
        end
        checks++;
        if (lat !== e.lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d required %0d", name, lat, e.lat);
        end
        if (busy_chk) begin
            checks++;
            if (busy_bad) begin
                errors++;
                $display("FAIL %s_busy: in_ready seen 1 required 0", name);
            end
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || result !== e.res || flags !== e.flg ||
                in_ready !== 1'b0 || status !== exp_status) begin
                errors++;
                $display("FAIL %s_hold%0d: ov=%b res=%h flg=%b rdy=%b st=%b required 1 %h %b 0 %b",
                         name, i, out_valid, result, flags, in_ready, status,
                         e.res, e.flg, exp_status);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (e.sbit) exp_status = e.flg;
        checks++;
        if (status !== exp_status || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_handoff: status=%b out_valid=%b required %b 0",
                     name, status, out_valid, exp_status);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 32'h0 ||
            flags !== 4'b0000 || status !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: rdy=%b ov=%b res=%h flg=%b st=%b required 0 0 0 0 0",
                     in_ready, out_valid, result, flags, status);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
        exp_status = 4'b0000;
    endtask

    task automatic test_sub_sbc();
        send(OP_SUB, 32'd5, 32'd5, 1'b0, 1'b0, 32'h0, 4'b0110, 1);
        recv("sub", 1'b0, 0, 1'b0);
        send(OP_SBC, 32'd0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b1000, 1);
        recv("sbc", 1'b0, 0, 1'b0);
    endtask

    task automatic test_add();
        send(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 32'h8000_0000, 4'b1001, 1);
        recv("add_ovf", 1'b0, 0, 1'b0);
        send(OP_ADC, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 4'b0110, 1);
        recv("adc_carry", 1'b0, 0, 1'b0);
    endtask

    task automatic test_mul();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] p;
        send(OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 32'h0,
             {1'b0, 1'b1, exp_status[FLAG_C], exp_status[FLAG_V]}, 33);
        recv("mul_wrap", 1'b1, 0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            a = $urandom; b = $urandom;
            p = a * b;
            send(OP_MUL, a, b, 1'b0, 1'b0, p,
                 {p[W-1], p == 32'h0, exp_status[FLAG_C], exp_status[FLAG_V]}, 33);
            recv("mul_rand", 1'b0, 0, 1'b1);
        end
    endtask

    task automatic test_shifts();
        send(OP_LSR, 32'h3, 32'd1, 1'b0, 1'b0, 32'h1, 4'b0010, 1);
        recv("lsr1", 1'b0, 0, 1'b0);
        send(OP_ASR, 32'h8000_0000, 32'd31, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'b1000, 1);
        recv("asr31", 1'b0, 0, 1'b0);
        send(OP_LSL, 32'h8000_0001, 32'h21, 1'b0, 1'b0, 32'h2, 4'b0010, 1);
        recv("lsl_wrapamt", 1'b0, 0, 1'b0);
        send(OP_LSR, 32'h5, 32'h0, 1'b0, 1'b0, 32'h5, 4'b0000, 1);
        recv("lsr0", 1'b0, 0, 1'b0);
        send(OP_ASR, 32'h4000_0000, 32'd30, 1'b0, 1'b0, 32'h1, 4'b0000, 1);
        recv("asr_pos", 1'b0, 0, 1'b0);
    endtask

    task automatic test_logic();
        logic [3:0]   ops [5];
        logic [3:0]   bad [3];
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        ops[0] = OP_MOV; ops[1] = OP_MVN; ops[2] = OP_AND; ops[3] = OP_ORR; ops[4] = OP_EOR;
        bad[0] = 4'b0000; bad[1] = 4'b1110; bad[2] = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            op = ops[i]; a = $urandom; b = $urandom;
            case (i)
                0: r = b;
                1: r = ~b;
                2: r = a & b;
                3: r = a | b;
                default: r = a ^ b;
            endcase
            send(op, a, b, 1'b1, 1'b0, r, {r[W-1], r == 32'h0, 2'b00}, 1);
            recv("logic", 1'b0, 0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            send(bad[i], $urandom, $urandom, 1'b1, 1'b0, 32'h0, 4'b0100, 1);
            recv("bad_op", 1'b0, 0, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        send(OP_ADD, 32'h1, 32'h1, 1'b0, 1'b1, 32'h2, 4'b0000, 1);
        recv("backpressure", 1'b0, 5, 1'b0);
    endtask

    task automatic test_back_to_back();
        send(OP_SUB, 32'd3, 32'd5, 1'b0, 1'b1, 32'hFFFF_FFFE, 4'b1000, 1);
        recv("b2b_sub", 1'b1, 0, 1'b0);
        send(OP_SUB, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0011, 1);
        recv("b2b_subovf", 1'b1, 0, 1'b0);
        send(OP_MOV, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 4'b0100, 1);
        recv("b2b_mov", 1'b1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_mul();
        send(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 32'h8000_0000, 4'b1001, 1);
        recv("pre_rst_add", 1'b0, 0, 1'b0);
        send(OP_MUL, 32'd3, 32'd4, 1'b0, 1'b0, 32'd12, 4'b0001, 33);
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || status !== 4'b0000 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midmul_reset: ov=%b st=%b rdy=%b required 0 0000 0",
                     out_valid, status, in_ready);
        end
        tick(); tick();
        rst_n = 1'b1;
        sb.delete();
        exp_status = 4'b0000;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midmul_release: rdy=%b ov=%b required 1 0", in_ready, out_valid);
        end
        send(OP_ADD, 32'd2, 32'd3, 1'b0, 1'b0, 32'd5, 4'b0000, 1);
        recv("post_rst_add", 1'b0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sub_sbc();
        test_add();
        test_mul();
        test_shifts();
        test_logic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32; datapath width in bits, legal values 8..64.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH); width of the shift amount taken from src_b.
REQ-003 clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  the operation on src_a/src_b/alu_op/c_in/s_bit is valid.
REQ-006 in_ready  output  1  the block accepts an operation this cycle.
REQ-007 src_a  input  WIDTH  operand A.
REQ-008 src_b  input  WIDTH  operand B, or shift amount in its low SHAMT_W bits.
REQ-009 alu_op  input  4  operation code.
REQ-010 c_in  input  1  carry in, used by ADC/SBC.
REQ-011 s_bit  input  1  update the status register from this result.
REQ-012 out_valid  output  1  result/flags hold a completed operation.
REQ-013 out_ready  input  1  the consumer takes the result this cycle.
REQ-014 result  output  WIDTH  operation result.
REQ-015 flags  output  4  {N,Z,C,V} of this result.
REQ-016 status  output  4  registered {N,Z,C,V} status register.

Function
REQ-017 Opcodes: 0001 MOV=B; 1001 MVN=~B; 0010 ADD=A+B; 0011 ADC=A+B+c_in; 0100 SUB=A-B; 0101 SBC=A-B-(1-c_in); 0110 AND; 0111 ORR; 1000 EOR; 1010 MUL; 1011 LSL; 1100 LSR; 1101 ASR; any other code -> result 0, C=0, V=0.
REQ-018 Add/sub: computed at WIDTH+1 bits; ADD/ADC C = bit WIDTH; SUB/SBC C = NOT borrow; V = signed overflow of the WIDTH-bit operation.
REQ-019 Logic ops, MOV, MVN and the default code: C=0, V=0.
REQ-020 Shifts: amount = src_b[SHAMT_W-1:0]; C = last bit shifted out, or 0 when amount=0; V=0; ASR replicates A[WIDTH-1].
REQ-021 MUL: low WIDTH bits of unsigned A*B by iterative shift-add, one bit per cycle, WIDTH iterations; C and V equal status C and V at acceptance.
REQ-022 All ops: N = result[WIDTH-1]; Z = (result == 0).
REQ-023 FSM states: IDLE, MUL_RUN, HOLD. IDLE->HOLD on accepting a non-MUL op; IDLE->MUL_RUN on accepting MUL; MUL_RUN->HOLD after the WIDTH-th iteration; HOLD->IDLE when out_ready=1.
REQ-024 in_ready = 1 only in IDLE; accept = in_valid AND in_ready.
REQ-025 Latency: non-MUL out_valid 1 cycle after accept; MUL out_valid WIDTH+1 cycles after accept.
REQ-026 out_valid = 1 only in HOLD; result/flags stay stable while out_valid=1 and out_ready=0.
REQ-027 Operands are captured at accept; input changes afterwards do not affect the operation in flight.
REQ-028 status <= flags on the handoff cycle (out_valid AND out_ready) when the captured s_bit=1; otherwise status holds.
REQ-029 out_ready asserted while not in HOLD has no effect.

Reset
REQ-030 rst_n low, at any time including mid-MUL: FSM -> IDLE; result=0, flags=0, status=0, out_valid=0; any in-flight operation is discarded.
REQ-031 in_ready = 0 while rst_n is low; in_ready = 1 from the first clk edge after reset is released.

Structure
REQ-032 Package alu_pkg holds the opcode localparams, the FSM state enum and the flag bit indices (N=3, Z=2, C=1, V=0).
REQ-033 Sub-module alu_mul_iter (start, done, WIDTH-parametrised shift-add multiplier) implements MUL; the remaining datapath is inline in seq_alu.

Verification
REQ-034 WIDTH=32, ADD 0x7FFFFFFF+1, s_bit=1 -> result 0x80000000, flags N=1 Z=0 C=0 V=1, out_valid 1 cycle after accept, status=1001 after handoff.
REQ-035 SUB 5-5, then SBC 0-0 with c_in=0 -> first result 0, Z=1 C=1; second result 0xFFFFFFFF, N=1 C=0 V=0.
REQ-036 MUL 0x10000*0x10000, out_ready=1 -> result 0, Z=1, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
REQ-037 LSR A=0x3, amount 1 -> result 0x1, C=1; ASR A=0x80000000, amount 31 -> result 0xFFFFFFFF, C=0.
REQ-038 out_ready held 0 for 5 cycles after result -> result/flags stable, in_ready=0, status unchanged until the handoff cycle.
REQ-039 rst_n pulsed low 10 cycles into a MUL -> out_valid=0, status=0, in_ready=1 on the first edge after release, next ADD 2+3 returns 5.
